// File: rtl/ow_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ow_pkg
//  Description : Shared 1-Wire master definitions. Holds the engine state
//                encoding, the Dallas/Maxim CRC-8 polynomial and default bus
//                timing used by the reset/presence, write and read engines.
//  Revision    : 1.0  initial release
// ============================================================================
package ow_pkg;

    // Read engine sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SLOT = 2'd1,
        ST_DONE = 2'd2
    } ow_state_e;

    // Reflected form of x^8 + x^5 + x^4 + 1
    localparam logic [7:0] c_CRC8_POLY = 8'h8C;

    // Default time-slot timing, in system clock cycles
    localparam int c_DEF_INIT_CYCLES     = 5;
    localparam int c_DEF_SAMPLE_CYCLE    = 13;
    localparam int c_DEF_SLOT_CYCLES     = 60;
    localparam int c_DEF_RECOVERY_CYCLES = 2;

    // Default reset/presence timing shared with the reset engine
    localparam int c_DEF_RSTL_CYCLES     = 480;
    localparam int c_DEF_PRESENCE_SAMPLE = 70;

    // One serial step of the reflected CRC-8: feedback is LSB xor new bit
    function automatic logic [7:0] crc8_step(input logic [7:0] crc_in,
                                             input logic       bit_in);
        logic [7:0] nxt;
        nxt = crc_in >> 1;
        if (crc_in[0] ^ bit_in) begin
            nxt = nxt ^ c_CRC8_POLY;
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ow_crc8.sv
`default_nettype none
// ============================================================================
//  Module      : ow_crc8
//  Description : Serial Dallas/Maxim CRC-8 accumulator. clr has priority over
//                en; one bit is absorbed per enabled cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module ow_crc8
    import ow_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;

    // Next CRC value: clear on a new transaction, else fold in the new bit
    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = 8'h00;
        end else if (en) begin
            crc_d = crc8_step(crc_q, bit_in);
        end
    end

    // CRC register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule
`default_nettype wire

// File: rtl/ow_read_engine.sv
`default_nettype none
// ============================================================================
//  Module      : ow_read_engine
//  Description : 1-Wire master read engine. Generates NUM_BITS read time
//                slots on an open-drain bus, samples each bit LSB first,
//                streams it out and optionally checks a CRC-8 over the run.
//  Revision    : 1.0  initial release
// ============================================================================
module ow_read_engine
    import ow_pkg::*;
#(
    parameter int NUM_BITS        = 64,
    parameter int INIT_CYCLES     = c_DEF_INIT_CYCLES,
    parameter int SAMPLE_CYCLE    = c_DEF_SAMPLE_CYCLE,
    parameter int SLOT_CYCLES     = c_DEF_SLOT_CYCLES,
    parameter int RECOVERY_CYCLES = c_DEF_RECOVERY_CYCLES,
    parameter int CRC_EN          = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                bus_in,
    output logic                bus_drive_low,
    output logic                busy,
    output logic                done,
    output logic                bit_valid,
    output logic                bit_data,
    output logic [NUM_BITS-1:0] data,
    output logic                crc_ok
);

    // Slot period and derived counter/index widths
    localparam int PERIOD = SLOT_CYCLES + RECOVERY_CYCLES;
    localparam int CNT_W  = (PERIOD > 1)   ? $clog2(PERIOD)   : 1;
    localparam int IDX_W  = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    localparam logic [CNT_W-1:0] c_CNT_LAST   = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] c_CNT_SAMPLE = CNT_W'(SAMPLE_CYCLE);
    localparam logic [CNT_W-1:0] c_CNT_INIT   = CNT_W'(INIT_CYCLES);
    localparam logic [IDX_W-1:0] c_IDX_LAST   = IDX_W'(NUM_BITS - 1);

    ow_state_e           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NUM_BITS-1:0] data_q, data_d;
    logic                sync1_q, sync2_q;
    logic                drive_q, drive_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                bit_valid_q, bit_valid_d;
    logic                bit_data_q, bit_data_d;
    logic                crc_ok_q, crc_ok_d;
    logic                w_crc_clr;
    logic                w_sample;
    logic [7:0]          w_crc;

    // Two-flop synchroniser for the asynchronous pad level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus_in;
            sync2_q <= sync1_q;
        end
    end

    // Sequencing: slot counter, bit index, capture and completion decisions
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        data_d      = data_q;
        done_d      = 1'b0;
        bit_valid_d = 1'b0;
        bit_data_d  = bit_data_q;
        crc_ok_d    = crc_ok_q;
        w_crc_clr   = 1'b0;
        w_sample    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // abort in the same cycle suppresses the start
                if (start && !abort) begin
                    state_d   = ST_SLOT;
                    cnt_d     = '0;
                    idx_d     = '0;
                    data_d    = '0;
                    crc_ok_d  = 1'b0;
                    w_crc_clr = 1'b1;
                end
            end
            ST_SLOT: begin
                if (abort) begin
                    // Partial data is kept; the run is not reported as good
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    crc_ok_d = 1'b0;
                end else begin
                    if (cnt_q == c_CNT_SAMPLE) begin
                        data_d[idx_q] = sync2_q;
                        bit_valid_d   = 1'b1;
                        bit_data_d    = sync2_q;
                        w_sample      = 1'b1;
                    end
                    if (cnt_q == c_CNT_LAST) begin
                        cnt_d = '0;
                        if (idx_q == c_IDX_LAST) begin
                            // Last sample was taken long before, so the CRC is final
                            state_d  = ST_DONE;
                            done_d   = 1'b1;
                            crc_ok_d = (w_crc == 8'h00);
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they align with it
        busy_d  = (state_d == ST_SLOT);
        drive_d = (state_d == ST_SLOT) && (cnt_d < c_CNT_INIT);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            drive_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_data_q  <= 1'b0;
            crc_ok_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            drive_q     <= drive_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bit_valid_q <= bit_valid_d;
            bit_data_q  <= bit_data_d;
            crc_ok_q    <= crc_ok_d;
        end
    end

    // Optional CRC checker; without it the result is always reported good
    generate
        if (CRC_EN != 0) begin : g_crc
            ow_crc8 u_crc8 (
                .clk    (clk),
                .rst    (rst),
                .clr    (w_crc_clr),
                .en     (w_sample),
                .bit_in (sync2_q),
                .crc    (w_crc)
            );
            assign crc_ok = crc_ok_q;
        end else begin : g_no_crc
            assign w_crc  = 8'h00;
            assign crc_ok = 1'b1;
        end
    endgenerate

    assign bus_drive_low = drive_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign bit_valid     = bit_valid_q;
    assign bit_data      = bit_data_q;
    assign data          = data_q;

endmodule
`default_nettype wire

// File: tb/tb_ow_read_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ow_read_engine
//  Description : Self-checking bench for ow_read_engine. An open-drain bus
//                model replays a ROM image slot by slot; expected timing,
//                data and CRC come from a slot-arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ow_read_engine;

    localparam int P      = 62;
    localparam int INIT   = 5;
    localparam int SAMPLE = 13;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default instance
    logic        start_a, abort_a, drv_a, busy_a, done_a, bv_a, bd_a, crc_a;
    logic        bus_a;
    logic [63:0] data_a;
    // NUM_BITS=8, CRC disabled instance
    logic        start_b, abort_b, drv_b, busy_b, done_b, bv_b, bd_b, crc_b;
    logic        bus_b;
    logic [7:0]  data_b;

    // Slave bit currently presented; open-drain wired-AND with the master
    logic slave_bit;
    assign bus_a = slave_bit & ~drv_a;
    assign bus_b = slave_bit & ~drv_b;

    ow_read_engine u_dut (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .bus_in(bus_a),
        .bus_drive_low(drv_a), .busy(busy_a), .done(done_a), .bit_valid(bv_a),
        .bit_data(bd_a), .data(data_a), .crc_ok(crc_a)
    );

    ow_read_engine #(.NUM_BITS(8), .CRC_EN(0)) u_dut8 (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .bus_in(bus_b),
        .bus_drive_low(drv_b), .busy(busy_b), .done(done_b), .bit_valid(bv_b),
        .bit_data(bd_b), .data(data_b), .crc_ok(crc_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Byte-wise reference CRC over the first nbits of v (nbits multiple of 8)
    function automatic logic [7:0] ref_crc(input logic [255:0] v, input int nbits);
        logic [7:0] c;
        c = 8'h00;
        for (int b = 0; b < nbits / 8; b++) begin
            c = c ^ v[b*8 +: 8];
            for (int i = 0; i < 8; i++) begin
                c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
            end
        end
        return c;
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start_a = v; else start_b = v;
    endtask

    task automatic set_abort(input int sel, input logic v);
        if (sel == 0) abort_a = v; else abort_b = v;
    endtask

    // One transaction: start, replay rom, check per-cycle slot shape against
    // slot arithmetic, then check data/crc. abort_c/mid_c < 0 means unused.
    task automatic run_txn(input string tag, input int sel, input logic [255:0] rom,
                           input int nbits, input int abort_c, input int mid_c,
                           input logic exp_crc);
        int total, shape_err, nvalid, exp_nvalid;
        logic [255:0] exp_data, obs_data;
        logic live, e_drv, e_valid, e_done;
        logic o_busy, o_drv, o_valid, o_data, o_done;
        total      = nbits * P;
        shape_err  = 0;
        nvalid     = 0;
        exp_nvalid = 0;
        exp_data   = '0;
        for (int k = 0; k < nbits; k++) begin
            if (abort_c < 0 || k * P + SAMPLE < abort_c) begin
                exp_data[k] = rom[k];
                exp_nvalid++;
            end
        end
        @(negedge clk);
        set_start(sel, 1'b1);
        slave_bit = 1'b1;
        @(negedge clk);
        set_start(sel, 1'b0);
        for (int c = 0; c <= total + 2; c++) begin
            live    = (c < total) && (abort_c < 0 || c <= abort_c);
            e_drv   = live && ((c % P) < INIT);
            e_valid = live && ((c % P) == SAMPLE + 1);
            e_done  = (abort_c < 0) && (c == total);
            o_busy  = (sel == 0) ? busy_a : busy_b;
            o_drv   = (sel == 0) ? drv_a  : drv_b;
            o_valid = (sel == 0) ? bv_a   : bv_b;
            o_data  = (sel == 0) ? bd_a   : bd_b;
            o_done  = (sel == 0) ? done_a : done_b;
            if (o_busy !== live || o_drv !== e_drv || o_valid !== e_valid || o_done !== e_done)
                shape_err++;
            if (e_valid && o_data !== rom[c / P])
                shape_err++;
            if (o_valid === 1'b1)
                nvalid++;
            slave_bit = (c < total) ? rom[c / P] : 1'b1;
            set_abort(sel, c == abort_c);
            set_start(sel, c == mid_c);
            @(negedge clk);
        end
        set_abort(sel, 1'b0);
        set_start(sel, 1'b0);
        obs_data = (sel == 0) ? {192'b0, data_a} : {248'b0, data_b};
        check({tag, "_shape"}, shape_err, 0);
        check({tag, "_nvalid"}, nvalid, exp_nvalid);
        check({tag, "_data"}, obs_data, exp_data);
        check({tag, "_crc_ok"}, (sel == 0) ? crc_a : crc_b, exp_crc);
    endtask

    initial begin
        logic [63:0]  rom;
        logic [255:0] r;
        int ac;
        rst = 1'b1; start_a = 0; abort_a = 0; start_b = 0; abort_b = 0; slave_bit = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {drv_a, busy_a, done_a, bv_a, bd_a, data_a, crc_a}, '0);
        rst = 1'b0;
        @(negedge clk);

        // Known ROM image with a valid CRC byte
        rom = 64'hA200_0000_01B8_1C02;
        run_txn("rom", 0, {192'b0, rom}, 64, -1, -1, 1'b1);

        // Single corrupted bit must break the CRC
        rom[12] = ~rom[12];
        check("rom_flip_model", ref_crc({192'b0, rom}, 64) != 8'h00, 1'b1);
        run_txn("rom_flip", 0, {192'b0, rom}, 64, -1, -1, ref_crc({192'b0, rom}, 64) == 8'h00);

        // Bus held high (slot shape checked every cycle)
        run_txn("ones", 0, {192'b0, {64{1'b1}}}, 64, -1, -1, ref_crc({192'b0, {64{1'b1}}}, 64) == 8'h00);

        // Random 7-byte payloads with appended CRC; one also pokes start while busy
        for (int i = 0; i < 3; i++) begin
            r = {200'b0, $urandom_range(255, 0), $urandom, $urandom} & {200'b0, {56{1'b1}}};
            r[63:56] = ref_crc(r, 56);
            run_txn("rand_crc", 0, r, 64, -1, (i == 1) ? 1000 : -1, 1'b1);
        end

        // Raw random image, CRC judged by the model
        r = {192'b0, $urandom, $urandom};
        run_txn("rand_raw", 0, r, 64, -1, -1, ref_crc(r, 64) == 8'h00);

        // Abort while slot 3 drives low: bits 0..2 kept
        r = {192'b0, $urandom, $urandom};
        run_txn("abort190", 0, r, 64, 190, -1, 1'b0);

        // Random abort point, avoiding the sample cycle itself
        ac = $urandom_range(10 * P, P);
        if (ac % P == SAMPLE) ac++;
        r = {192'b0, $urandom, $urandom};
        run_txn("abort_rand", 0, r, 64, ac, -1, 1'b0);

        // start together with abort in IDLE is ignored
        @(negedge clk);
        start_a = 1'b1; abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; abort_a = 1'b0;
        check("start_abort_busy", busy_a, 1'b0);
        check("start_abort_drv", drv_a, 1'b0);
        repeat (3) @(negedge clk);
        check("start_abort_idle", busy_a, 1'b0);

        // Asynchronous reset during the low phase of slot 1
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        slave_bit = 1'b1;
        repeat (64) @(negedge clk);
        check("pre_rst_drv", drv_a, 1'b1);
        #2 rst = 1'b1;
        #1 check("async_rst", {drv_a, busy_a, done_a, bv_a, bd_a, data_a, crc_a}, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 8-bit instance without CRC
        r = {248'b0, 8'($urandom)};
        run_txn("nb8", 1, r, 8, -1, -1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
